// File: rtl/pad_mux_pkg.sv
// Shared types for the pad multiplexer: config byte layout, decoded config
// struct and the per-pad switching state.
package pad_mux_pkg;

    localparam int CfgSelLsb  = 0;
    localparam int CfgSelW    = 4;
    localparam int CfgPenBit  = 4;
    localparam int CfgInEnBit = 5;

    typedef struct packed {
        logic [1:0] rsvd;
        logic       in_en;
        logic       pen;
        logic [3:0] func_sel;
    } pad_cfg_t;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_GAP    = 1'b1
    } pad_state_e;

    // Reserved bits never get stored, so a readback always shows them as 0.
    function automatic pad_cfg_t cfg_from_byte(input logic [7:0] b);
        pad_cfg_t c;
        c.rsvd     = 2'b00;
        c.in_en    = b[CfgInEnBit];
        c.pen      = b[CfgPenBit];
        c.func_sel = b[CfgSelLsb +: CfgSelW];
        return c;
    endfunction

endpackage

// File: rtl/pad_mux_channel.sv
// One pad: config register, function-switch guard FSM with hi-Z gap counter,
// and the input synchroniser feeding the selected function.
//
// state     | meaning
// ST_ACTIVE | pad driven / sampled by the selected function (if sel is valid)
// ST_GAP    | function switch in progress; pad hi-Z, inputs blocked
module pad_mux_channel
    import pad_mux_pkg::*;
#(
    parameter int         NumFunc    = 4,
    parameter int         SyncStages = 2,
    parameter int         GapCycles  = 2,
    parameter logic [7:0] ResetCfg   = 8'h30
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_i,
    input  logic [7:0]         wdata_i,
    output logic [7:0]         cfg_o,
    input  logic [NumFunc-1:0] func_oe_i,
    input  logic [NumFunc-1:0] func_out_i,
    output logic [NumFunc-1:0] func_in_o,
    output logic               pad_oen_o,
    output logic               pad_i_o,
    output logic               pad_pen_o,
    input  logic               pad_o_i
);

    localparam int       CntW   = $clog2(GapCycles + 1);
    localparam pad_cfg_t CfgRst = cfg_from_byte(ResetCfg);

    pad_cfg_t                cfg_q;
    pad_state_e              state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [SyncStages-1:0]   sync_q;
    logic                    sel_change;

    assign sel_change = wr_i && (wdata_i[CfgSelLsb +: CfgSelW] != cfg_q.func_sel);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q   <= CfgRst;
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            sync_q  <= '0;
        end else begin
            if (wr_i) begin
                cfg_q <= cfg_from_byte(wdata_i);
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[SyncStages-2:0], pad_o_i};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sel_change) begin
            state_d = ST_GAP;
            cnt_d   = CntW'(GapCycles);
        end else if (state_q == ST_GAP) begin
            // Terminal count: the last gap cycle hands the pad back.
            if (cnt_q <= CntW'(1)) begin
                state_d = ST_ACTIVE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_comb begin
        pad_oen_o = 1'b1;
        pad_i_o   = 1'b0;
        func_in_o = '0;
        if (state_q == ST_ACTIVE) begin
            for (int f = 0; f < NumFunc; f++) begin
                if (cfg_q.func_sel == 4'(f)) begin
                    pad_oen_o    = ~func_oe_i[f];
                    pad_i_o      = func_out_i[f];
                    func_in_o[f] = cfg_q.in_en & sync_q[SyncStages-1];
                end
            end
        end
    end

    assign pad_pen_o = cfg_q.pen;
    assign cfg_o     = cfg_q;

endmodule

// File: rtl/pad_mux_ctrl.sv
// Pad multiplexer top: always-ready config port with one-cycle read response,
// and one pad_mux_channel per pad.
module pad_mux_ctrl
    import pad_mux_pkg::*;
#(
    parameter int         NumPads    = 16,
    parameter int         NumFunc    = 4,
    parameter int         SyncStages = 2,
    parameter int         GapCycles  = 2,
    parameter logic [7:0] ResetCfg   = 8'h30,
    localparam int        AddrW      = (NumPads > 1) ? $clog2(NumPads) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cfg_req_i,
    input  logic                             cfg_we_i,
    input  logic [AddrW-1:0]                 cfg_addr_i,
    input  logic [7:0]                       cfg_wdata_i,
    output logic [7:0]                       cfg_rdata_o,
    output logic                             cfg_gnt_o,
    output logic                             cfg_rvalid_o,
    input  logic [NumFunc-1:0][NumPads-1:0]  func_oe_i,
    input  logic [NumFunc-1:0][NumPads-1:0]  func_out_i,
    output logic [NumFunc-1:0][NumPads-1:0]  func_in_o,
    output logic [NumPads-1:0]               pad_oen_o,
    output logic [NumPads-1:0]               pad_i_o,
    output logic [NumPads-1:0]               pad_pen_o,
    input  logic [NumPads-1:0]               pad_o_i
);

    logic [NumPads-1:0]              wr;
    logic [NumPads-1:0][7:0]         cfg_all;
    logic [NumPads-1:0][NumFunc-1:0] fin_pf;
    logic [7:0]                      rdata_d, rdata_q;
    logic                            rvalid_q;

    assign cfg_gnt_o = cfg_req_i;

    for (genvar p = 0; p < NumPads; p++) begin : g_pad
        logic [NumFunc-1:0] oe_c, out_c;

        for (genvar f = 0; f < NumFunc; f++) begin : g_func
            assign oe_c[f]  = func_oe_i[f][p];
            assign out_c[f] = func_out_i[f][p];
        end

        // Out-of-range addresses match no pad, so such writes are dropped.
        assign wr[p] = cfg_req_i & cfg_we_i & (cfg_addr_i == AddrW'(p));

        pad_mux_channel #(
            .NumFunc    (NumFunc),
            .SyncStages (SyncStages),
            .GapCycles  (GapCycles),
            .ResetCfg   (ResetCfg)
        ) u_chan (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .wr_i       (wr[p]),
            .wdata_i    (cfg_wdata_i),
            .cfg_o      (cfg_all[p]),
            .func_oe_i  (oe_c),
            .func_out_i (out_c),
            .func_in_o  (fin_pf[p]),
            .pad_oen_o  (pad_oen_o[p]),
            .pad_i_o    (pad_i_o[p]),
            .pad_pen_o  (pad_pen_o[p]),
            .pad_o_i    (pad_o_i[p])
        );
    end

    always_comb begin
        func_in_o = '0;
        for (int p = 0; p < NumPads; p++) begin
            for (int f = 0; f < NumFunc; f++) begin
                func_in_o[f][p] = fin_pf[p][f];
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        if (cfg_req_i && !cfg_we_i) begin
            for (int p = 0; p < NumPads; p++) begin
                if (cfg_addr_i == AddrW'(p)) begin
                    rdata_d = cfg_all[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= cfg_req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign cfg_rvalid_o = rvalid_q;
    assign cfg_rdata_o  = rdata_q;

endmodule
